// File: rtl/player_controller.sv
`default_nettype none
// ============================================================================
//  Module      : player_controller
//  Description : Player position, lives, level and game-state keeper for the
//                road-crossing game. Button presses become one grid step each,
//                applied only on frame_tick so the image never tears. The moved
//                player is tested against four car rectangles; a hit, a
//                level completion or game over is handled here.
//  Ports       : CLK/RST              clock, synchronous active-high reset
//                frame_tick           one-cycle pulse at start of v-blank
//                btn_up/down/left/right synchronised active-high buttons
//                car_x..car_y4        top-left corners of the four cars
//                player_x/player_y    registered player top-left position
//                lives, level         remaining lives, current level 0..15
//                game_over            high while in OVER
//                hit_pulse            one-cycle pulse on collision
//                level_up_pulse       one-cycle pulse on reaching the top row
//  Revision    : 1.0 - initial release
// ============================================================================
module player_controller #(
    parameter int H_DISPLAY     = 640,
    parameter int V_DISPLAY     = 480,
    parameter int PLAYER_WIDTH  = 32,
    parameter int PLAYER_HEIGHT = 32,
    parameter int CAR_WIDTH     = 64,
    parameter int CAR_HEIGHT    = 32,
    parameter int STEP          = 32,
    parameter int HOLD_FRAMES   = 4,
    parameter int FREEZE_FRAMES = 30,
    parameter int LIVES_INIT    = 3
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       frame_tick,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       btn_left,
    input  logic       btn_right,
    input  logic [9:0] car_x,
    input  logic [9:0] car_y,
    input  logic [9:0] car_x2,
    input  logic [9:0] car_y2,
    input  logic [9:0] car_x3,
    input  logic [9:0] car_y3,
    input  logic [9:0] car_x4,
    input  logic [9:0] car_y4,
    output logic [9:0] player_x,
    output logic [9:0] player_y,
    output logic [1:0] lives,
    output logic [3:0] level,
    output logic       game_over,
    output logic       hit_pulse,
    output logic       level_up_pulse
);

    localparam int          c_HOLD_W   = $clog2(HOLD_FRAMES + 1);
    localparam int          c_FRZ_W    = $clog2(FREEZE_FRAMES + 1);
    localparam logic [9:0]  c_START_X  = 10'((H_DISPLAY - PLAYER_WIDTH) / 2);
    localparam logic [9:0]  c_START_Y  = 10'(V_DISPLAY - PLAYER_HEIGHT);
    localparam logic [10:0] c_X_MAX    = 11'(H_DISPLAY - PLAYER_WIDTH);
    localparam logic [10:0] c_Y_MAX    = 11'(V_DISPLAY - PLAYER_HEIGHT);
    localparam logic [10:0] c_STEP     = 11'(STEP);
    localparam logic [10:0] c_CAR_W    = 11'(CAR_WIDTH);
    localparam logic [10:0] c_CAR_H    = 11'(CAR_HEIGHT);
    localparam logic [10:0] c_PL_W     = 11'(PLAYER_WIDTH);
    localparam logic [10:0] c_PL_H     = 11'(PLAYER_HEIGHT);
    localparam logic [c_HOLD_W-1:0] c_HOLD   = c_HOLD_W'(HOLD_FRAMES);
    localparam logic [c_FRZ_W-1:0]  c_FREEZE = c_FRZ_W'(FREEZE_FRAMES);
    localparam logic [1:0]  c_LIVES    = 2'(LIVES_INIT);

    localparam logic [1:0]  c_ST_PLAY  = 2'd0;
    localparam logic [1:0]  c_ST_HIT   = 2'd1;
    localparam logic [1:0]  c_ST_WIN   = 2'd2;
    localparam logic [1:0]  c_ST_OVER  = 2'd3;

    // Button vectors are ordered by move priority: [3]=up [2]=down [1]=left [0]=right
    logic [3:0]          r_prev_q, r_pend_q, w_pend_d;
    logic [9:0]          r_x_q, w_x_d, r_y_q, w_y_d;
    logic [1:0]          r_lives_q, w_lives_d;
    logic [3:0]          r_level_q, w_level_d;
    logic [1:0]          r_state_q, w_state_d;
    logic [c_HOLD_W-1:0] r_hold_q, w_hold_d;
    logic [c_FRZ_W-1:0]  r_freeze_q, w_freeze_d;
    logic                r_over_q, r_hit_q, w_hit_d, r_lup_q, w_lup_d;

    logic [3:0]  w_btn, w_rise, w_car_hit;
    logic [10:0] w_x11, w_y11, w_nx, w_ny;
    logic        w_move;
    logic [9:0]  w_cx [4];
    logic [9:0]  w_cy [4];

    assign w_btn  = {btn_up, btn_down, btn_left, btn_right};
    assign w_rise = w_btn & ~r_prev_q;
    assign w_x11  = {1'b0, r_x_q};
    assign w_y11  = {1'b0, r_y_q};

    assign w_cx[0] = car_x;   assign w_cy[0] = car_y;
    assign w_cx[1] = car_x2;  assign w_cy[1] = car_y2;
    assign w_cx[2] = car_x3;  assign w_cy[2] = car_y3;
    assign w_cx[3] = car_x4;  assign w_cy[3] = car_y4;

    function automatic logic f_overlap(input logic [10:0] nx, input logic [10:0] ny,
                                       input logic [10:0] cx, input logic [10:0] cy);
        return (nx < cx + c_CAR_W) && (cx < nx + c_PL_W) &&
               (ny < cy + c_CAR_H) && (cy < ny + c_PL_H);
    endfunction

    // Candidate position: highest-priority pending direction, saturated at the walls
    always_comb begin
        w_nx   = w_x11;
        w_ny   = w_y11;
        w_move = 1'b1;
        if (r_pend_q[3])
            w_ny = (w_y11 >= c_STEP) ? w_y11 - c_STEP : 11'd0;
        else if (r_pend_q[2])
            w_ny = (w_y11 + c_STEP > c_Y_MAX) ? c_Y_MAX : w_y11 + c_STEP;
        else if (r_pend_q[1])
            w_nx = (w_x11 >= c_STEP) ? w_x11 - c_STEP : 11'd0;
        else if (r_pend_q[0])
            w_nx = (w_x11 + c_STEP > c_X_MAX) ? c_X_MAX : w_x11 + c_STEP;
        else
            w_move = 1'b0;
    end

    for (genvar gi = 0; gi < 4; gi++) begin : g_car
        assign w_car_hit[gi] = f_overlap(w_nx, w_ny, {1'b0, w_cx[gi]}, {1'b0, w_cy[gi]});
    end

    always_comb begin
        w_x_d      = r_x_q;
        w_y_d      = r_y_q;
        w_lives_d  = r_lives_q;
        w_level_d  = r_level_q;
        w_state_d  = r_state_q;
        w_hold_d   = r_hold_q;
        w_freeze_d = r_freeze_q;
        w_hit_d    = 1'b0;
        w_lup_d    = 1'b0;

        // Clear on the tick first, then accept this cycle's edges so none is lost
        w_pend_d = frame_tick ? 4'b0000 : r_pend_q;
        if (r_state_q == c_ST_PLAY && r_hold_q == '0)
            w_pend_d = w_pend_d | w_rise;

        if (r_state_q == c_ST_OVER && (|w_rise)) begin
            // Restart does not wait for a frame boundary
            w_lives_d = c_LIVES;
            w_level_d = 4'd0;
            w_x_d     = c_START_X;
            w_y_d     = c_START_Y;
            w_hold_d  = '0;
            w_state_d = c_ST_PLAY;
        end else if (frame_tick) begin
            w_hold_d = (r_hold_q != '0) ? r_hold_q - 1'b1 : '0;
            case (r_state_q)
                c_ST_PLAY: begin
                    if (w_move)
                        w_hold_d = c_HOLD;
                    if (|w_car_hit) begin
                        w_hit_d = 1'b1;
                        w_x_d   = c_START_X;
                        w_y_d   = c_START_Y;
                        if (r_lives_q == 2'd1) begin
                            w_lives_d = 2'd0;
                            w_state_d = c_ST_OVER;
                        end else begin
                            w_lives_d  = r_lives_q - 2'd1;
                            w_state_d  = c_ST_HIT;
                            w_freeze_d = c_FREEZE;
                        end
                    end else if (w_ny == 11'd0) begin
                        w_lup_d    = 1'b1;
                        w_level_d  = (r_level_q == 4'd15) ? 4'd15 : r_level_q + 4'd1;
                        w_x_d      = c_START_X;
                        w_y_d      = c_START_Y;
                        w_state_d  = c_ST_WIN;
                        w_freeze_d = c_FREEZE;
                    end else begin
                        w_x_d = w_nx[9:0];
                        w_y_d = w_ny[9:0];
                    end
                end
                c_ST_HIT, c_ST_WIN: begin
                    w_freeze_d = (r_freeze_q != '0) ? r_freeze_q - 1'b1 : '0;
                    if (r_freeze_q <= c_FRZ_W'(1))
                        w_state_d = c_ST_PLAY;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_prev_q   <= 4'b0000;
            r_pend_q   <= 4'b0000;
            r_x_q      <= c_START_X;
            r_y_q      <= c_START_Y;
            r_lives_q  <= c_LIVES;
            r_level_q  <= 4'd0;
            r_state_q  <= c_ST_PLAY;
            r_hold_q   <= '0;
            r_freeze_q <= '0;
            r_over_q   <= 1'b0;
            r_hit_q    <= 1'b0;
            r_lup_q    <= 1'b0;
        end else begin
            r_prev_q   <= w_btn;
            r_pend_q   <= w_pend_d;
            r_x_q      <= w_x_d;
            r_y_q      <= w_y_d;
            r_lives_q  <= w_lives_d;
            r_level_q  <= w_level_d;
            r_state_q  <= w_state_d;
            r_hold_q   <= w_hold_d;
            r_freeze_q <= w_freeze_d;
            r_over_q   <= (w_state_d == c_ST_OVER);
            r_hit_q    <= w_hit_d;
            r_lup_q    <= w_lup_d;
        end
    end

    assign player_x       = r_x_q;
    assign player_y       = r_y_q;
    assign lives          = r_lives_q;
    assign level          = r_level_q;
    assign game_over      = r_over_q;
    assign hit_pulse      = r_hit_q;
    assign level_up_pulse = r_lup_q;

endmodule
`default_nettype wire
